// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Expands a RISC-V instruction immediate field (I/S/B/U/J, and optionally
//   Z) to XLEN bits. Results sit in a two-entry pipeline stage: an output
//   register plus one skid register. The skid register lets in_ready be a
//   registered signal, so there is no combinational path from out_ready.
//
//   Configuration macro: IMM_EXTEND_PIPE_ZIMM_EN
//     defined   -> ImmSrc=5 gives the zero-extended CSR uimm i_imm[19:15]
//     undefined -> ImmSrc=5 is illegal: I-format result with imm_err=1
//
//   Parameters
//     XLEN   datapath width, 32 or 64
//     TAG_W  width of the sideband tag
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     flush      synchronous kill of both held entries
//     in_valid   upstream offers an entry
//     in_ready   skid register is empty, so an entry can be taken
//     i_imm      instruction bits [31:7]
//     ImmSrc     format select: I=0 S=1 B=2 U=3 J=4 Z=5
//     in_tag     sideband carried with the entry
//     out_valid  result available
//     out_ready  downstream takes the result
//     ImmExt     extended immediate
//     out_tag    tag of the presented result
//     imm_err    presented result came from an illegal ImmSrc

module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      i_imm,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             imm_err
);

  // Combinational extension of the offered entry
  logic [XLEN-1:0]  ext_imm_s;
  logic             ext_err_s;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic             out_err_q,   out_err_d;

  // Skid register
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_err_q,   skid_err_d;

  logic             accept_s;
  logic             transfer_s;

  // Handshake qualifiers; in_ready depends only on registered state
  assign in_ready   = ~skid_valid_q;
  assign accept_s   = in_valid & ~skid_valid_q;
  assign transfer_s = out_valid_q & out_ready;

  // Immediate extension: every signed format replicates bit 31 up to XLEN
  always_comb begin
    ext_imm_s = {XLEN{1'b0}};
    ext_err_s = 1'b0;
    case (ImmSrc)
      3'd0: ext_imm_s = {{(XLEN-12){i_imm[31]}}, i_imm[31:20]};
      3'd1: ext_imm_s = {{(XLEN-12){i_imm[31]}}, i_imm[31:25], i_imm[11:7]};
      3'd2: ext_imm_s = {{(XLEN-12){i_imm[31]}}, i_imm[7], i_imm[30:25],
                         i_imm[11:8], 1'b0};
      // U: sign-extend the 20-bit field first, then shift, so bit 31 fills
      // the upper half when XLEN=64 and nothing is lost when XLEN=32
      3'd3: ext_imm_s = {{(XLEN-20){i_imm[31]}}, i_imm[31:12]} << 12;
      3'd4: ext_imm_s = {{(XLEN-20){i_imm[31]}}, i_imm[19:12], i_imm[20],
                         i_imm[30:21], 1'b0};
`ifdef IMM_EXTEND_PIPE_ZIMM_EN
      3'd5: ext_imm_s = {{(XLEN-5){1'b0}}, i_imm[19:15]};
`endif
      default: begin
        // Illegal selector: fall back to the I-format value and flag it
        ext_imm_s = {{(XLEN-12){i_imm[31]}}, i_imm[31:20]};
        ext_err_s = 1'b1;
      end
    endcase
  end

  // Next-state logic for the output/skid pair; flush wins over everything
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (transfer_s) begin
      if (skid_valid_q) begin
        // Skid is full, so in_ready was low and nothing new was accepted
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        out_valid_d = 1'b1;
        out_imm_d   = ext_imm_s;
        out_tag_d   = in_tag;
        out_err_d   = ext_err_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      if (out_valid_q) begin
        // Output is stalled: park the new entry behind it
        skid_valid_d = 1'b1;
        skid_imm_d   = ext_imm_s;
        skid_tag_d   = in_tag;
        skid_err_d   = ext_err_s;
      end else begin
        out_valid_d = 1'b1;
        out_imm_d   = ext_imm_s;
        out_tag_d   = in_tag;
        out_err_d   = ext_err_s;
      end
    end else begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= {XLEN{1'b0}};
      out_tag_q    <= {TAG_W{1'b0}};
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= {XLEN{1'b0}};
      skid_tag_q   <= {TAG_W{1'b0}};
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ImmExt    = out_imm_q;
  assign out_tag   = out_tag_q;
  assign imm_err   = out_err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Directed bench for imm_extend_pipe. Two instances share the same
//   stimulus: one at XLEN=32 and one at XLEN=64, so sign extension to both
//   widths is observed on every vector.

module tb_imm_extend_pipe;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [31:7]      i_imm;
  logic [2:0]       ImmSrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready_32,  in_ready_64;
  logic             out_valid_32, out_valid_64;
  logic [31:0]      imm_32;
  logic [63:0]      imm_64;
  logic [TAG_W-1:0] tag_32, tag_64;
  logic             err_32, err_64;

  int n_checks;
  int n_fail;

  imm_extend_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut_32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_32),
    .i_imm(i_imm), .ImmSrc(ImmSrc), .in_tag(in_tag),
    .out_valid(out_valid_32), .out_ready(out_ready),
    .ImmExt(imm_32), .out_tag(tag_32), .imm_err(err_32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut_64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_64),
    .i_imm(i_imm), .ImmSrc(ImmSrc), .in_tag(in_tag),
    .out_valid(out_valid_64), .out_ready(out_ready),
    .ImmExt(imm_64), .out_tag(tag_64), .imm_err(err_64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] instr, input logic [TAG_W-1:0] t);
    ImmSrc = src;
    i_imm  = instr[31:7];
    in_tag = t;
  endtask

  // One entry through an idle pipe with out_ready=1: result appears after one edge
  task automatic vec(input string name, input logic [2:0] src, input logic [31:0] instr,
                     input logic [TAG_W-1:0] t, input logic [31:0] e32,
                     input logic [63:0] e64, input logic eerr);
    drive(src, instr, t);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({name, "_valid"}, {63'd0, out_valid_32}, 64'd1);
    check({name, "_imm32"}, {32'd0, imm_32}, {32'd0, e32});
    check({name, "_imm64"}, imm_64, e64);
    check({name, "_err"},   {63'd0, err_32}, {63'd0, eerr});
    check({name, "_err64"}, {63'd0, err_64}, {63'd0, eerr});
    check({name, "_tag"},   {59'd0, tag_32}, {59'd0, t});
    step();
    check({name, "_drain"}, {63'd0, out_valid_32}, 64'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(3'd0, 32'h0, 5'd0);

    // Reset values while rst_n is low
    step();
    check("rst_out_valid", {63'd0, out_valid_32}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready_32},  64'd1);
    check("rst_imm",       {32'd0, imm_32},       64'd0);
    check("rst_tag",       {59'd0, tag_32},       64'd0);
    check("rst_err",       {63'd0, err_32},       64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();

    // Format vectors
    vec("I",   3'd0, 32'hFFF00093, 5'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    vec("B",   3'd2, 32'hFE000EE3, 5'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    vec("J",   3'd4, 32'h0080006F, 5'd3, 32'h00000008, 64'h0000000000000008, 1'b0);
    vec("S",   3'd1, 32'hFE112E23, 5'd4, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    vec("Uneg",3'd3, 32'h80000037, 5'd5, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    vec("Upos",3'd3, 32'h12345037, 5'd6, 32'h12345000, 64'h0000000012345000, 1'b0);
`ifdef IMM_EXTEND_PIPE_ZIMM_EN
    vec("Z",   3'd5, 32'h0001D073, 5'd7, 32'h00000003, 64'h0000000000000003, 1'b0);
`else
    vec("Z",   3'd5, 32'h0001D073, 5'd7, 32'h00000000, 64'h0000000000000000, 1'b1);
`endif
    vec("Src7",3'd7, 32'hFFF00093, 5'd8, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    vec("Src6",3'd6, 32'h12300013, 5'd9, 32'h00000123, 64'h0000000000000123, 1'b1);

    // Backpressure: tags 1,2,3 with immediate = tag (I-format)
    out_ready = 1'b0;
    drive(3'd0, 32'h00100013, 5'd1);
    in_valid = 1'b1;
    step();
    check("bp1_valid", {63'd0, out_valid_32}, 64'd1);
    check("bp1_ready", {63'd0, in_ready_32},  64'd1);
    drive(3'd0, 32'h00200013, 5'd2);
    step();
    check("bp2_tag",   {59'd0, tag_32},       64'd1);
    check("bp2_ready", {63'd0, in_ready_32},  64'd0);
    drive(3'd0, 32'h00300013, 5'd3);
    step();
    check("bp3_tag",   {59'd0, tag_32},       64'd1);
    check("bp3_imm",   {32'd0, imm_32},       64'd1);
    check("bp3_ready", {63'd0, in_ready_32},  64'd0);
    out_ready = 1'b1;
    step();
    check("rel1_tag",   {59'd0, tag_32},      64'd2);
    check("rel1_imm",   {32'd0, imm_32},      64'd2);
    check("rel1_ready", {63'd0, in_ready_32}, 64'd1);
    step();
    in_valid = 1'b0;
    check("rel2_valid", {63'd0, out_valid_32}, 64'd1);
    check("rel2_tag",   {59'd0, tag_32},       64'd3);
    check("rel2_imm",   {32'd0, imm_32},       64'd3);
    step();
    check("rel3_empty", {63'd0, out_valid_32}, 64'd0);

    // Flush with both entries full and a new offer pending
    out_ready = 1'b0;
    drive(3'd0, 32'h00400013, 5'd4);
    in_valid = 1'b1;
    step();
    drive(3'd0, 32'h00500013, 5'd5);
    step();
    check("fl_full", {63'd0, in_ready_32}, 64'd0);
    drive(3'd0, 32'h00600013, 5'd6);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", {63'd0, out_valid_32}, 64'd0);
    check("fl_ready", {63'd0, in_ready_32},  64'd1);
    out_ready = 1'b1;
    step();
    check("fl_nostale", {63'd0, out_valid_32}, 64'd0);
    vec("postfl", 3'd0, 32'h00700013, 5'd7, 32'h00000007, 64'h0000000000000007, 1'b0);

    // Accept while flushing into an empty pipe is also discarded
    drive(3'd0, 32'h00A00013, 5'd10);
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_empty_accept", {63'd0, out_valid_32}, 64'd0);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    drive(3'd0, 32'h00B00013, 5'd11);
    in_valid = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid_32}, 64'd0);
    check("arst_ready", {63'd0, in_ready_32},  64'd1);
    check("arst_imm",   {32'd0, imm_32},       64'd0);
    check("arst_tag",   {59'd0, tag_32},       64'd0);
    drive(3'd0, 32'h00C00013, 5'd12);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", {63'd0, out_valid_32}, 64'd1);
    check("post_rst_tag",   {59'd0, tag_32},       64'd12);
    check("post_rst_imm",   {32'd0, imm_32},       64'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag (e.g. rd index).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1, synchronous kill of all held entries.
REQ-006 SHALL have port in_valid, input, 1, upstream entry offered.
REQ-007 SHALL have port in_ready, output, 1, block accepts entry this cycle.
REQ-008 SHALL have port i_imm, input, 25 ([31:7]), raw instruction immediate field.
REQ-009 SHALL have port ImmSrc, input, imm_t (3), format select: I=0, S=1, B=2, U=3, J=4, Z=5.
REQ-010 SHALL have port in_tag, input, TAG_W, sideband carried unchanged.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port ImmExt, output, XLEN, extended immediate.
REQ-014 SHALL have port out_tag, output, TAG_W, tag of the presented result.
REQ-015 SHALL have port imm_err, output, 1, presented result had an illegal ImmSrc.

Function
REQ-016 SHALL accept an entry on a cycle where in_valid && in_ready, and SHALL transfer an entry on a cycle where out_valid && out_ready.
REQ-017 SHALL compute the extension combinationally on input and register it; latency 1 cycle from accept to out_valid when the output stage is empty.
REQ-018 SHALL produce: I {sext i_imm[31:20]}; S {sext i_imm[31:25],i_imm[11:7]}; B {sext i_imm[31],i_imm[7],i_imm[30:25],i_imm[11:8],0}; J {sext i_imm[31],i_imm[19:12],i_imm[20],i_imm[30:21],0}.
REQ-019 SHALL produce U as i_imm[31:12] followed by 12 zeros, with bit 31 sign-extended to XLEN when XLEN=64.
REQ-020 SHALL sign-extend all signed formats to full XLEN.
REQ-021 SHALL treat ImmSrc 6, 7 (and 5 when Z is compiled out) as illegal: I-format result, imm_err=1.
REQ-022 SHALL hold two entries: output register plus one skid register; in_ready = skid register empty (registered, no combinational path from out_ready).
REQ-023 SHALL, when the output register is stalled (out_valid && !out_ready) and an entry is accepted, capture that entry in the skid register.
REQ-024 SHALL, on a transfer with the skid register full, move the skid entry to the output register in the same edge; order strictly FIFO.
REQ-025 SHALL, on a transfer with the skid register empty and a simultaneous accept, load the new entry directly into the output register.
REQ-026 SHALL keep ImmExt, out_tag, imm_err stable while out_valid && !out_ready.
REQ-027 SHALL, on flush, clear both valid bits at the next edge, discard any entry accepted that cycle, and present in_ready=1 the following cycle; flush overrides all simultaneous events.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force out_valid=0, skid empty, in_ready=1, ImmExt=0, out_tag=0, imm_err=0.
REQ-029 SHALL discard any in-flight entry on reset assertion mid-operation; first acceptance possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with IMM_EXTEND_PIPE_ZIMM_EN defined, support Z (ImmSrc=5): ImmExt = zero-extended i_imm[19:15] (CSR uimm), imm_err=0.
REQ-031 SHALL, without IMM_EXTEND_PIPE_ZIMM_EN, treat ImmSrc=5 as illegal per REQ-021.

Verification
REQ-032 SHALL cover: XLEN=32, I, i_imm from 0xFFF00093 -> ImmExt=0xFFFFFFFF one cycle later, imm_err=0.
REQ-033 SHALL cover: B from 0xFE000EE3 -> 0xFFFFFFFC; J from 0x0080006F -> 0x00000008; S from 0xFE112E23 -> 0xFFFFFFFC.
REQ-034 SHALL cover: XLEN=64, U from 0x80000037 -> 0xFFFFFFFF80000000; U from 0x12345037 -> 0x0000000012345000.
REQ-035 SHALL cover: out_ready=0 for 3 cycles, 3 back-to-back entries tags 1,2,3 -> tag1 held at output, tag2 in skid, in_ready=0, tag3 held upstream; release -> outputs 1,2,3 in order with no loss or duplication.
REQ-036 SHALL cover: flush with both entries full and in_valid=1 -> out_valid=0 and in_ready=1 next cycle, no stale tag emitted.
REQ-037 SHALL cover: ImmSrc=5, i_imm from 0x0001D073 -> 0x00000003, imm_err=0 with macro; I-format result 0x00000000, imm_err=1 without macro; ImmSrc=7 -> imm_err=1 in both builds.
